// File: rtl/ctrl_useq_if.sv
// ----------------------------------------------------------------------------
// ctrl_useq_if
//   Opcode-in / control-beat-out handshake bundle for ctrl_useq.
//
//   Opcode side (front end -> sequencer):
//     in_valid  opcode offered
//     in_ready  opcode accepted when in_valid & in_ready
//     in_op     opcode, OP_W bits
//   Beat side (sequencer -> datapath):
//     out_valid control beat present
//     out_ready beat consumed when out_valid & out_ready
//     out_cw    control word, CW_W bits
//     out_step  step index within the current opcode, STEP_W bits
//     out_last  current step is the final one
//
//   The master modport is the front end / datapath side (drives opcodes and
//   out_ready). The slave modport is the sequencer.
// ----------------------------------------------------------------------------
interface ctrl_useq_if #(
  parameter int OP_W   = 7,
  parameter int CW_W   = 26,
  parameter int STEP_W = 2
);
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_op;
  logic              out_valid;
  logic              out_ready;
  logic [CW_W-1:0]   out_cw;
  logic [STEP_W-1:0] out_step;
  logic              out_last;

  modport master (
    output in_valid, in_op, out_ready,
    input  in_ready, out_valid, out_cw, out_step, out_last
  );

  modport slave (
    input  in_valid, in_op, out_ready,
    output in_ready, out_valid, out_cw, out_step, out_last
  );
endinterface

// File: rtl/ctrl_useq.sv
// ----------------------------------------------------------------------------
// ctrl_useq
//   Registered, micro-sequenced control decoder. Each opcode indexes a
//   run-time-loadable table entry {len, cw}; the opcode is then issued as
//   len+1 consecutive control beats carrying the same cw and a step index.
//
//   Ports:
//     clk       clock, rising edge
//     rst_n     synchronous active-low reset (clears table and in-flight op)
//     cfg_we    table write strobe
//     cfg_addr  table entry written
//     cfg_data  entry value {len, cw}; len = steps - 1
//     bus       ctrl_useq_if.slave: opcode handshake in, control beats out
//     busy      equals out_valid
//   Optional (CTRL_USEQ_PARITY_EN defined):
//     cfg_pinv  invert stored parity on write (fault injection)
//     out_perr  parity mismatch of the latched entry, held for the whole op
//
//   Build option macro: CTRL_USEQ_PARITY_EN
// ----------------------------------------------------------------------------
module ctrl_useq #(
  parameter int OP_W   = 7,
  parameter int CW_W   = 26,
  parameter int STEP_W = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [OP_W-1:0]        cfg_addr,
  input  logic [STEP_W+CW_W-1:0] cfg_data,
`ifdef CTRL_USEQ_PARITY_EN
  input  logic                   cfg_pinv,
  output logic                   out_perr,
`endif
  ctrl_useq_if.slave             bus,
  output logic                   busy
);

  localparam int DEPTH  = 1 << OP_W;
  localparam int DATA_W = STEP_W + CW_W;
`ifdef CTRL_USEQ_PARITY_EN
  localparam int ENT_W  = DATA_W + 1;   // parity bit on top
`else
  localparam int ENT_W  = DATA_W;
`endif

  typedef enum logic {S_IDLE = 1'b0, S_ISSUE = 1'b1} state_e;

  // Decode table, flop based so it can be cleared in one reset cycle.
  logic [ENT_W-1:0] tbl_q [DEPTH];
  logic [ENT_W-1:0] wr_entry;
  logic [ENT_W-1:0] rd_entry;
  logic [STEP_W-1:0] rd_len;
  logic [CW_W-1:0]   rd_cw;

  state_e            state_q, state_d;
  logic [STEP_W-1:0] len_q, len_d;
  logic [CW_W-1:0]   cw_q, cw_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              last_q, last_d;
`ifdef CTRL_USEQ_PARITY_EN
  logic              perr_q, perr_d;
`endif

  logic accept;
  logic load;

`ifdef CTRL_USEQ_PARITY_EN
  // Stored bit makes the whole entry even parity unless cfg_pinv corrupts it.
  assign wr_entry = {(^cfg_data) ^ cfg_pinv, cfg_data};
`else
  assign wr_entry = cfg_data;
`endif

  // Table write. The read below sees the pre-edge contents, so a write to
  // the accepted address in the acceptance cycle does not affect that op.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= '0;
      end
    end else if (cfg_we) begin
      tbl_q[cfg_addr] <= wr_entry;
    end
  end

  assign rd_entry = tbl_q[bus.in_op];
  assign rd_cw    = rd_entry[CW_W-1:0];
  assign rd_len   = rd_entry[DATA_W-1:CW_W];

  // A new op may enter when idle, or when the final beat of the current op
  // retires this cycle (zero-bubble chaining).
  assign bus.in_ready = (state_q == S_IDLE) | (bus.out_ready & last_q);
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cw_d    = cw_q;
    step_d  = step_q;
    last_d  = last_q;
`ifdef CTRL_USEQ_PARITY_EN
    perr_d  = perr_q;
`endif
    load    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_ISSUE;
          load    = 1'b1;
        end
      end
      S_ISSUE: begin
        if (bus.out_ready) begin
          if (!last_q) begin
            step_d = step_q + STEP_W'(1);
            last_d = ((step_q + STEP_W'(1)) == len_q);
          end else if (accept) begin
            load = 1'b1;
          end else begin
            state_d = S_IDLE;
            last_d  = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Latch the whole entry at acceptance; later table writes cannot reach it.
    if (load) begin
      len_d  = rd_len;
      cw_d   = rd_cw;
      step_d = '0;
      last_d = (rd_len == '0);
`ifdef CTRL_USEQ_PARITY_EN
      perr_d = ^rd_entry;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cw_q    <= '0;
      step_q  <= '0;
      last_q  <= 1'b0;
`ifdef CTRL_USEQ_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cw_q    <= cw_d;
      step_q  <= step_d;
      last_q  <= last_d;
`ifdef CTRL_USEQ_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign bus.out_valid = (state_q == S_ISSUE);
  assign bus.out_cw    = cw_q;
  assign bus.out_step  = step_q;
  assign bus.out_last  = last_q;
  assign busy          = (state_q == S_ISSUE);
`ifdef CTRL_USEQ_PARITY_EN
  assign out_perr      = perr_q;
`endif

endmodule

// File: tb/tb_ctrl_useq.sv
// ----------------------------------------------------------------------------
// tb_ctrl_useq
//   Directed self-checking bench for ctrl_useq. Inputs are driven and
//   outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_ctrl_useq;
  localparam int OP_W   = 7;
  localparam int CW_W   = 26;
  localparam int STEP_W = 2;

  logic                   clk;
  logic                   rst_n;
  logic                   cfg_we;
  logic [OP_W-1:0]        cfg_addr;
  logic [STEP_W+CW_W-1:0] cfg_data;
  logic                   busy;
`ifdef CTRL_USEQ_PARITY_EN
  logic                   cfg_pinv;
  logic                   out_perr;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  ctrl_useq_if #(.OP_W(OP_W), .CW_W(CW_W), .STEP_W(STEP_W)) bus ();

  ctrl_useq #(.OP_W(OP_W), .CW_W(CW_W), .STEP_W(STEP_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
`ifdef CTRL_USEQ_PARITY_EN
    .cfg_pinv (cfg_pinv),
    .out_perr (out_perr),
`endif
    .bus      (bus),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Advance one cycle; returns at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cfg_write(input logic [OP_W-1:0] a, input logic [STEP_W-1:0] l,
                           input logic [CW_W-1:0] c);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = {l, c};
    tick();
    cfg_we   = 1'b0;
  endtask

  // Check one beat's full output state.
  task automatic beat(input string tag, input logic [CW_W-1:0] c,
                      input logic [STEP_W-1:0] s, input logic l);
    check({tag, ".valid"}, 64'(bus.out_valid), 64'(1));
    check({tag, ".cw"},    64'(bus.out_cw),    64'(c));
    check({tag, ".step"},  64'(bus.out_step),  64'(s));
    check({tag, ".last"},  64'(bus.out_last),  64'(l));
  endtask

  localparam logic [CW_W-1:0] CW_A = 26'h2A5_5A5A;

  initial begin
    rst_n        = 1'b0;
    cfg_we       = 1'b0;
    cfg_addr     = '0;
    cfg_data     = '0;
    bus.in_valid = 1'b0;
    bus.in_op    = '0;
    bus.out_ready= 1'b0;
`ifdef CTRL_USEQ_PARITY_EN
    cfg_pinv     = 1'b0;
`endif
    @(negedge clk);
    tick();
    rst_n = 1'b1;

    // Reset state
    check("rst.valid", 64'(bus.out_valid), 64'(0));
    check("rst.cw",    64'(bus.out_cw),    64'(0));
    check("rst.step",  64'(bus.out_step),  64'(0));
    check("rst.last",  64'(bus.out_last),  64'(0));
    check("rst.busy",  64'(busy),          64'(0));
    check("rst.ready", 64'(bus.in_ready),  64'(1));

    // T1: unwritten entry decodes to cw=0, single beat
    bus.in_valid = 1'b1; bus.in_op = 7'h05; bus.out_ready = 1'b1;
    check("t1.ready_acc", 64'(bus.in_ready), 64'(1));
    tick();
    bus.in_valid = 1'b0;
    beat("t1.b0", '0, 2'd0, 1'b1);
    check("t1.ready_b0", 64'(bus.in_ready), 64'(1));
    check("t1.busy_b0",  64'(busy),         64'(1));
    tick();
    check("t1.idle", 64'(bus.out_valid), 64'(0));
    check("t1.ready_idle", 64'(bus.in_ready), 64'(1));

    // T2: three-step op under continuous out_ready
    cfg_write(7'h12, 2'd2, CW_A);
    bus.in_valid = 1'b1; bus.in_op = 7'h12;
    tick();
    bus.in_valid = 1'b0;
    for (int s = 0; s < 3; s++) begin
      beat($sformatf("t2.b%0d", s), CW_A, 2'(s), s == 2);
      tick();
    end
    check("t2.idle", 64'(bus.out_valid), 64'(0));

    // T3: stall on step 1 for three cycles
    bus.in_valid = 1'b1; bus.in_op = 7'h12;
    tick();
    bus.in_valid = 1'b0;
    beat("t3.b0", CW_A, 2'd0, 1'b0);
    tick();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      beat($sformatf("t3.stall%0d", k), CW_A, 2'd1, 1'b0);
      check($sformatf("t3.ready%0d", k), 64'(bus.in_ready), 64'(0));
      tick();
    end
    bus.out_ready = 1'b1;
    beat("t3.b1", CW_A, 2'd1, 1'b0);
    tick();
    beat("t3.b2", CW_A, 2'd2, 1'b1);
    tick();
    check("t3.idle", 64'(bus.out_valid), 64'(0));

    // T4: back-to-back 0x12 then 0x01, no bubble
    cfg_write(7'h01, 2'd0, 26'h0000123);
    bus.in_valid = 1'b1; bus.in_op = 7'h12;
    tick();
    bus.in_op = 7'h01;
    beat("t4.b0", CW_A, 2'd0, 1'b0);
    check("t4.ready0", 64'(bus.in_ready), 64'(0));
    tick();
    beat("t4.b1", CW_A, 2'd1, 1'b0);
    check("t4.ready1", 64'(bus.in_ready), 64'(0));
    tick();
    beat("t4.b2", CW_A, 2'd2, 1'b1);
    check("t4.ready2", 64'(bus.in_ready), 64'(1));
    tick();
    bus.in_valid = 1'b0;
    beat("t4.b3", 26'h0000123, 2'd0, 1'b1);
    tick();
    check("t4.idle", 64'(bus.out_valid), 64'(0));

    // T5: write to same address in acceptance cycle keeps old entry
    cfg_we = 1'b1; cfg_addr = 7'h12; cfg_data = {2'd0, 26'h1};
    bus.in_valid = 1'b1; bus.in_op = 7'h12;
    tick();
    cfg_we = 1'b0; bus.in_valid = 1'b0;
    for (int s = 0; s < 3; s++) begin
      beat($sformatf("t5.old%0d", s), CW_A, 2'(s), s == 2);
      tick();
    end
    check("t5.idle", 64'(bus.out_valid), 64'(0));
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    beat("t5.new", 26'h1, 2'd0, 1'b1);
    tick();
    check("t5.idle2", 64'(bus.out_valid), 64'(0));

`ifdef CTRL_USEQ_PARITY_EN
    // T6: parity fault injection
    cfg_pinv = 1'b1;
    cfg_write(7'h33, 2'd1, 26'h5);
    cfg_pinv = 1'b0;
    cfg_write(7'h34, 2'd0, 26'h7);
    bus.in_valid = 1'b1; bus.in_op = 7'h33;
    tick();
    bus.in_valid = 1'b0;
    beat("t6.b0", 26'h5, 2'd0, 1'b0);
    check("t6.perr0", 64'(out_perr), 64'(1));
    tick();
    beat("t6.b1", 26'h5, 2'd1, 1'b1);
    check("t6.perr1", 64'(out_perr), 64'(1));
    bus.in_valid = 1'b1; bus.in_op = 7'h34;
    tick();
    bus.in_valid = 1'b0;
    beat("t6.good", 26'h7, 2'd0, 1'b1);
    check("t6.perr_good", 64'(out_perr), 64'(0));
    tick();
`endif

    // T7: reset mid-sequence discards op, clears table, ignores cfg write
    cfg_write(7'h12, 2'd2, CW_A);
    bus.in_valid = 1'b1; bus.in_op = 7'h12;
    tick();
    bus.in_valid = 1'b0;
    tick();
    beat("t7.b1", CW_A, 2'd1, 1'b0);
    rst_n = 1'b0;
    cfg_we = 1'b1; cfg_addr = 7'h40; cfg_data = {2'd3, 26'h3FF_FFFF};
    tick();
    rst_n = 1'b1; cfg_we = 1'b0;
    check("t7.valid", 64'(bus.out_valid), 64'(0));
    check("t7.busy",  64'(busy),          64'(0));
    check("t7.step",  64'(bus.out_step),  64'(0));
    check("t7.last",  64'(bus.out_last),  64'(0));
    check("t7.cw",    64'(bus.out_cw),    64'(0));
    check("t7.ready", 64'(bus.in_ready),  64'(1));
    bus.in_valid = 1'b1; bus.in_op = 7'h12;
    tick();
    bus.in_op = 7'h40;
    beat("t7.clr12", '0, 2'd0, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    beat("t7.clr40", '0, 2'd0, 1'b1);
    tick();
    check("t7.idle", 64'(bus.out_valid), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog: the directed sequence is short, so this never fires
  // unless the bench itself is stuck.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
